// File: rtl/onetwo_stream_demux_pkg.sv
// Shared definitions for the 1:2 stream demultiplexer: FSM state encoding
// and default data/counter widths.
package onetwo_stream_demux_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

endpackage

// File: rtl/onetwo_stream_demux_out_slot.sv
// One-entry output register slice: a load fills the slot, a consumer ready
// empties it, and a simultaneous drain and load keeps it full without a bubble.
module onetwo_stream_demux_out_slot #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             last
);

  // data/last only change on a load, so they stay stable while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/onetwo_stream_demux.sv
// Registered 1:2 stream demultiplexer: routes a valid/ready stream to port 0
// or 1 by in_sel, holding the route for a whole packet, with per-port packet counters.
module onetwo_stream_demux
  import onetwo_stream_demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             in_sel,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  output logic             out0_last,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  output logic             out1_last,
  input  logic             out1_ready,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);

  state_t state_q, state_d;
  logic   lock_sel_q, lock_sel_d;
  logic   route, accept, load0, load1, inc0, inc1;

  // in_sel only matters on the first beat; later beats follow the locked port
  assign route    = (state_q == ST_IDLE) ? in_sel : lock_sel_q;
  assign in_ready = route ? (!out1_valid || out1_ready) : (!out0_valid || out0_ready);
  assign accept   = in_valid && in_ready;
  assign load0    = accept && !route;
  assign load1    = accept && route;
  assign busy     = (state_q == ST_LOCK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lock_sel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    inc0       = 1'b0;
    inc1       = 1'b0;
    if (accept) begin
      if (in_last) begin
        state_d = ST_IDLE;
        inc0    = !route;
        inc1    = route;
      end else if (state_q == ST_IDLE) begin
        state_d    = ST_LOCK;
        lock_sel_d = in_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      if (inc0) pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
      if (inc1) pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
    end
  end

  onetwo_stream_demux_out_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk       (clk),
    .rst       (rst),
    .load      (load0),
    .load_data (in_data),
    .load_last (in_last),
    .ready     (out0_ready),
    .valid     (out0_valid),
    .data      (out0_data),
    .last      (out0_last)
  );

  onetwo_stream_demux_out_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .load      (load1),
    .load_data (in_data),
    .load_last (in_last),
    .ready     (out1_ready),
    .valid     (out1_valid),
    .data      (out1_data),
    .last      (out1_last)
  );

endmodule

// File: tb/tb_onetwo_stream_demux.sv
// Scoreboard bench for onetwo_stream_demux: a packet-level reference model
// predicts each port's beat sequence, counters, busy and in_ready.
module tb_onetwo_stream_demux;

  logic       clk;
  logic       rst;
  logic [3:0] in_data;
  logic       in_valid, in_last, in_sel, in_ready;
  logic [3:0] out0_data, out1_data;
  logic       out0_valid, out0_last, out0_ready;
  logic       out1_valid, out1_last, out1_ready;
  logic       busy;
  logic [7:0] pkt_cnt0, pkt_cnt1;

  int nVectors = 0;
  int nMiscompares = 0;

  logic [4:0] q0[$];
  logic [4:0] q1[$];
  logic [7:0] mCnt0, mCnt1;
  logic       mInPkt, mLockSel;
  logic       stall0, stall1;
  logic [4:0] stallD0, stallD1;
  logic       randReady = 1'b0;

  onetwo_stream_demux #(.WIDTH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_sel     (in_sel),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_last  (out0_last),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_last  (out1_last),
    .out1_ready (out1_ready),
    .busy       (busy),
    .pkt_cnt0   (pkt_cnt0),
    .pkt_cnt1   (pkt_cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one beat and hold it until accepted; returns cycles spent
  task automatic applyStimulus(input logic [3:0] d, input logic l, input logic s, output int waited);
    logic acc;
    in_data  = d;
    in_last  = l;
    in_sel   = s;
    in_valid = 1'b1;
    waited   = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      waited++;
      if (acc) break;
      if (waited > 200) begin
        nVectors++;
        nMiscompares++;
        $display("[TB] FAIL accept_timeout: beat %0h not accepted within 200 cycles", d);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic doReset();
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  always @(posedge clk) begin
    if (randReady) begin
      #1;
      out0_ready = 1'($urandom_range(0, 1));
      out1_ready = 1'($urandom_range(0, 1));
    end
  end

  // Reference model and monitor: compares what the DUT shows now, then
  // records the beat that will be accepted at the coming rising edge
  always @(negedge clk) begin
    logic       occ0, occ1, route, expReady;
    logic [4:0] exp;
    if (rst) begin
      q0.delete();
      q1.delete();
      mCnt0 = 8'd0; mCnt1 = 8'd0;
      mInPkt = 1'b0; mLockSel = 1'b0;
      stall0 = 1'b0; stall1 = 1'b0;
    end else begin
      occ0 = (q0.size() != 0);
      occ1 = (q1.size() != 0);
      checkOutput("busy", busy, mInPkt);
      checkOutput("pkt_cnt0", pkt_cnt0, mCnt0);
      checkOutput("pkt_cnt1", pkt_cnt1, mCnt1);
      checkOutput("out0_valid", out0_valid, occ0);
      checkOutput("out1_valid", out1_valid, occ1);
      if (stall0) checkOutput("out0_hold", {out0_last, out0_data}, stallD0);
      if (stall1) checkOutput("out1_hold", {out1_last, out1_data}, stallD1);
      if (out0_valid && out0_ready && occ0) begin
        exp = q0.pop_front();
        checkOutput("out0_beat", {out0_last, out0_data}, exp);
      end
      if (out1_valid && out1_ready && occ1) begin
        exp = q1.pop_front();
        checkOutput("out1_beat", {out1_last, out1_data}, exp);
      end
      stall0 = out0_valid && !out0_ready; stallD0 = {out0_last, out0_data};
      stall1 = out1_valid && !out1_ready; stallD1 = {out1_last, out1_data};

      route    = mInPkt ? mLockSel : in_sel;
      expReady = route ? (!occ1 || out1_ready) : (!occ0 || out0_ready);
      checkOutput("in_ready", in_ready, expReady);
      if (in_valid && expReady) begin
        if (route) q1.push_back({in_last, in_data});
        else       q0.push_back({in_last, in_data});
        if (in_last) begin
          if (route) mCnt1 = mCnt1 + 8'd1;
          else       mCnt0 = mCnt0 + 8'd1;
          mInPkt = 1'b0;
        end else if (!mInPkt) begin
          mInPkt   = 1'b1;
          mLockSel = in_sel;
        end
      end
    end
  end

  initial begin
    int w, total, len;
    in_data = 4'd0; in_valid = 1'b0; in_last = 1'b0; in_sel = 1'b0;
    out0_ready = 1'b1; out1_ready = 1'b1;
    rst = 1'b1;
    doReset();

    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valids", {out0_valid, out1_valid, out0_last, out1_last}, 0);
    checkOutput("rst_out_data", {out0_data, out1_data}, 0);
    checkOutput("rst_cnts", {pkt_cnt0, pkt_cnt1, 7'd0, busy}, 0);
    @(posedge clk); #1;

    $display("[TB] single beat to port 0");
    applyStimulus(4'd15, 1'b1, 1'b0, w);
    @(negedge clk);
    checkOutput("t2_out0", {out0_valid, out0_data}, {1'b1, 4'd15});
    checkOutput("t2_out1_valid", out1_valid, 0);
    checkOutput("t2_cnt0", pkt_cnt0, 1);
    @(posedge clk); #1;

    $display("[TB] locked packet to port 1");
    applyStimulus(4'd8, 1'b0, 1'b1, w);
    @(negedge clk);
    checkOutput("t3_busy_b1", busy, 1);
    @(posedge clk); #1;
    applyStimulus(4'd9, 1'b0, 1'b0, w);
    applyStimulus(4'd10, 1'b1, 1'b0, w);
    @(negedge clk);
    checkOutput("t3_busy_end", busy, 0);
    checkOutput("t3_cnt1", pkt_cnt1, 1);
    checkOutput("t3_cnt0", pkt_cnt0, 1);
    @(posedge clk); #1;

    $display("[TB] reset while locked");
    out1_ready = 1'b0;
    applyStimulus(4'd7, 1'b0, 1'b1, w);
    @(negedge clk);
    checkOutput("lock_busy", busy, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("lockrst_state", {busy, out0_valid, out1_valid}, 0);
    checkOutput("lockrst_data", out1_data, 0);
    @(posedge clk); #1;
    out1_ready = 1'b1;

    $display("[TB] port 0 back-pressure");
    out0_ready = 1'b0;
    applyStimulus(4'd3, 1'b1, 1'b0, w);
    in_data = 4'd5; in_last = 1'b1; in_sel = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    checkOutput("t4_in_ready_blocked", in_ready, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("t4_out0_held", {out0_valid, out0_data}, {1'b1, 4'd3});
    @(posedge clk); #1;
    in_valid = 1'b0;
    applyStimulus(4'd6, 1'b1, 1'b1, w);
    checkOutput("t4_port1_accept_cycles", w, 1);
    out0_ready = 1'b1;
    applyStimulus(4'd5, 1'b1, 1'b0, w);

    $display("[TB] continuous stream");
    total = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(4'(i), (i == 15), (i == 0) ? 1'b0 : 1'($urandom_range(0, 1)), w);
      total += w;
    end
    checkOutput("t5_stream_cycles", total, 16);

    $display("[TB] counter wrap with random readies");
    doReset();
    randReady = 1'b1;
    for (int i = 0; i < 256; i++) applyStimulus(4'($urandom), 1'b1, 1'b0, w);
    randReady = 1'b0;
    @(posedge clk); #2;
    out0_ready = 1'b1; out1_ready = 1'b1;
    @(negedge clk);
    checkOutput("t6_cnt0_wrap", pkt_cnt0, 0);
    @(posedge clk); #1;

    $display("[TB] random packets");
    randReady = 1'b1;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++)
        applyStimulus(4'($urandom), (b == len - 1), 1'($urandom_range(0, 1)), w);
    end
    randReady = 1'b0;
    @(posedge clk); #2;
    out0_ready = 1'b1; out1_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("drain_q0_empty", q0.size(), 0);
    checkOutput("drain_q1_empty", q1.size(), 0);
    checkOutput("drain_valids", {out0_valid, out1_valid}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
